// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_N        default operand/result width
//   div_state_e  controller states
//   cnt_width()  iteration-counter width for a given operand width
package seq_divider_pkg;

    localparam int DIV_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Wide enough to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step (combinational).
//   rem_in   N+1-bit partial remainder, already shifted left with the next
//            dividend bit appended
//   dvsr     divisor magnitude
//   rem_out  next partial remainder (difference or restored value)
//   q_bit    quotient bit produced by this step
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] dvsr,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] diff;

    // The shifted remainder is below 2*dvsr <= 2^N, so the MSB of the
    // N+1-bit difference is a true sign bit.
    assign diff    = rem_in - {1'b0, dvsr};
    assign q_bit   = ~diff[N];
    assign rem_out = q_bit ? diff : rem_in;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per clock.
//   clk, reset   clock; asynchronous active-high reset
//   start        launches a division when sampled in IDLE
//   dividend     signed dividend, captured on the accepted start edge
//   divisor      signed divisor, captured on the accepted start edge
//   quotient     signed quotient, truncated toward zero (registered)
//   remainder    signed remainder, sign follows dividend (registered)
//   busy         high while a division is in flight
//   done         one-cycle pulse when results update
//   div_by_zero  set with the result when the captured divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(N);

    div_state_e state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     rem_q;    // partial remainder, always < divisor magnitude
    logic [N-1:0]     dvd_q;    // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]     dvs_q;    // divisor magnitude
    logic             sign_q, sign_r, zero_q;

    logic [N:0]       rem_shift, rem_next;
    logic             q_bit;
    logic             unused_rem_msb;

    assign rem_shift = {rem_q, dvd_q[N-1]};

    div_step #(.N(N)) u_step (
        .rem_in  (rem_shift),
        .dvsr    (dvs_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // A completed step leaves a remainder below the divisor, so bit N is 0.
    assign unused_rem_msb = rem_next[N];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == CNT_W'(N-1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // |-2^(N-1)| wraps to 2^(N-1), which is exact as unsigned.
                    dvd_q  <= dividend[N-1] ? -dividend : dividend;
                    dvs_q  <= divisor[N-1]  ? -divisor  : divisor;
                    sign_q <= dividend[N-1] ^ divisor[N-1];
                    sign_r <= dividend[N-1];
                    zero_q <= (divisor == '0);
                    rem_q  <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    rem_q <= rem_next[N-1:0];
                    dvd_q <= {dvd_q[N-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    // Zero divisor naturally yields |q|=all ones and r=|dividend|;
                    // the quotient is forced so a negative dividend still gives all ones.
                    quotient    <= zero_q ? '1 : (sign_q ? -dvd_q : dvd_q);
                    remainder   <= sign_r ? -rem_q : rem_q;
                    div_by_zero <= zero_q;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend, divisor;
    logic [N-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Launch one division and wait for done; lat = edges from accept to done.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", N'(busy), N'(1));
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic div_case(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
        int lat;
        run_div(a, b, lat);
        chk({tag, "_lat"}, N'(lat), N'(N+1));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, N'(div_by_zero), N'(ez));
        chk({tag, "_busy"}, N'(busy), N'(0));
    endtask

    initial begin
        int ndone, first_done, lat;
        logic [N-1:0] q5, r5;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("rst_q", quotient, 32'h0);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: exact positive division
        div_case("t1", 32'h1BB6BAA0, 32'h0000_0348, 32'h0008_7234, 32'h0, 1'b0);
        // 2: mixed signs, back-to-back launched during the done cycle
        div_case("t2a", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        div_case("t2b", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
        // 3: divide by zero, then flag cleared by a normal division
        div_case("t3a", 32'h50647236, 32'h0, 32'hFFFFFFFF, 32'h50647236, 1'b1);
        div_case("t3b", 32'h1BB6BAA5, 32'h0000_0348, 32'h0008_7234, 32'd5, 1'b0);
        // negative dividend by zero: quotient still all ones, remainder = dividend
        div_case("t3c", 32'hFFFFFF9C, 32'h0, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1);
        // 4: overflow wrap and divide by one
        div_case("t4a", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
        div_case("t4b", 32'hB887CAAF, 32'd1, 32'hB887CAAF, 32'h0, 1'b0);

        // 5: second start and operand changes during CALC are ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_done = 0; q5 = '0; r5 = '0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 4) begin
                start = 1'b1; dividend = 32'd7; divisor = 32'd7;
            end else if (i == 5) begin
                start = 1'b0; dividend = 32'd5; divisor = 32'd3;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = i; q5 = quotient; r5 = remainder;
                end
            end
        end
        chk("t5_ndone", N'(ndone), N'(1));
        chk("t5_lat", N'(first_done), N'(N+1));
        chk("t5_q", q5, 32'd100);
        chk("t5_r", r5, 32'd0);

        // 6: async reset mid-CALC abandons the division
        div_case("t6pre", 32'h50647236, 32'h0, 32'hFFFFFFFF, 32'h50647236, 1'b1);
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_q", quotient, 32'h0);
        chk("t6_rst_r", remainder, 32'h0);
        chk("t6_rst_dbz", N'(div_by_zero), N'(0));
        chk("t6_rst_busy", N'(busy), N'(0));
        chk("t6_rst_done", N'(done), N'(0));
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t6_no_done", N'(ndone), N'(0));
        div_case("t6post", 32'h1BB6BAA0, 32'h0000_0348, 32'h0008_7234, 32'h0, 1'b0);

        // done must be a single-cycle pulse
        @(posedge clk); #1;
        chk("done_pulse", N'(done), N'(0));
        run_div(32'd9, 32'd2, lat);
        chk("last_lat", N'(lat), N'(N+1));
        chk("last_q", quotient, 32'd4);
        chk("last_r", remainder, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
